// File: rtl/nav_pkg.sv
// Shared types and constants for the maze navigation controller.
package nav_pkg;

  localparam int unsigned SPD_W = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDG      = 2'd1,
    RAMP_UP  = 2'd2,
    RAMP_DWN = 2'd3
  } nav_state_t;

  localparam logic [SPD_W-1:0] INC_FAST = 11'h018;
  localparam logic [SPD_W-1:0] INC_NORM = 11'h002;

endpackage

// File: rtl/nav_edge_det.sv
// 1-bit registered rising-edge detector with a configurable reset value for the history flop.
module nav_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RST_VAL;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/maze_navigate.sv
// Heading/forward-move sequencer with speed ramp and wall-triggered stop.
// Build option: define NAV_FAST_SIM_EN for a large ramp increment (fast simulation).
module maze_navigate
  import nav_pkg::*;
#(
  parameter logic [10:0] MAX_FRWRD = 11'h2A0,
  parameter logic [10:0] MIN_FRWRD = 11'h0D0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strt_hdng,
  input  logic             strt_mv,
  input  logic             stp_lft,
  input  logic             stp_rght,
  input  logic             at_hdng,
  input  logic             lft_opn,
  input  logic             rght_opn,
  input  logic             frwrd_opn,
  output logic             mv_cmplt,
  output logic             moving,
  output logic             en_fusion,
  output logic [SPD_W-1:0] frwrd_spd
);

`ifdef NAV_FAST_SIM_EN
  localparam logic [SPD_W-1:0] INC = INC_FAST;
`else
  localparam logic [SPD_W-1:0] INC = INC_NORM;
`endif
  localparam logic [SPD_W-1:0] DEC_NORM  = SPD_W'(INC << 1);
  localparam logic [SPD_W-1:0] DEC_FAST  = SPD_W'(INC << 2);
  localparam logic [SPD_W-1:0] FUSE_THRS = SPD_W'(MAX_FRWRD >> 1);

  nav_state_t       state, nxt_state;
  logic [SPD_W-1:0] spd_nxt;
  logic [SPD_W-1:0] dec;
  logic [SPD_W-1:0] spd_sat;
  logic [SPD_W:0]   spd_sum;
  logic             dec_fast, dec_fast_nxt;
  logic             lft_rise_c, rght_rise_c;

  // History flops reset high so a wall already open at reset is not an edge.
  nav_edge_det #(.RST_VAL(1'b1)) u_lft_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (lft_opn),
    .rise_c (lft_rise_c)
  );

  nav_edge_det #(.RST_VAL(1'b1)) u_rght_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (rght_opn),
    .rise_c (rght_rise_c)
  );

  // Saturating increment done one bit wider so it can never wrap.
  assign spd_sum = {1'b0, frwrd_spd} + {1'b0, INC};
  assign spd_sat = (spd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : spd_sum[SPD_W-1:0];
  assign dec     = dec_fast ? DEC_FAST : DEC_NORM;

  // Next-state, next-speed and completion pulse.
  always_comb begin
    nxt_state    = state;
    spd_nxt      = frwrd_spd;
    dec_fast_nxt = dec_fast;
    mv_cmplt     = 1'b0;
    case (state)
      IDLE: begin
        spd_nxt = '0;
        if (strt_hdng) begin
          nxt_state = HDG;
        end else if (strt_mv) begin
          nxt_state    = RAMP_UP;
          spd_nxt      = MIN_FRWRD;
          dec_fast_nxt = 1'b0;
        end
      end
      HDG: begin
        spd_nxt = '0;
        if (at_hdng) begin
          mv_cmplt  = 1'b1;
          nxt_state = IDLE;
        end
      end
      RAMP_UP: begin
        // Blocked ahead takes priority over a side-wall stop.
        if (!frwrd_opn) begin
          nxt_state    = RAMP_DWN;
          dec_fast_nxt = 1'b1;
        end else if ((lft_rise_c && stp_lft) || (rght_rise_c && stp_rght)) begin
          nxt_state    = RAMP_DWN;
          dec_fast_nxt = 1'b0;
        end else begin
          spd_nxt = spd_sat;
        end
      end
      RAMP_DWN: begin
        if (frwrd_spd <= dec) begin
          spd_nxt   = '0;
          mv_cmplt  = 1'b1;
          nxt_state = IDLE;
        end else begin
          spd_nxt = frwrd_spd - dec;
          if (!frwrd_opn) dec_fast_nxt = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        spd_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frwrd_spd <= '0;
      dec_fast  <= 1'b0;
      moving    <= 1'b0;
      en_fusion <= 1'b0;
    end else begin
      state     <= nxt_state;
      frwrd_spd <= spd_nxt;
      dec_fast  <= dec_fast_nxt;
      moving    <= (nxt_state != IDLE);
      en_fusion <= (spd_nxt > FUSE_THRS);
    end
  end

endmodule
